sad_min_select: RTL
===================

// Module: sad_min_select
// PURPOSE
//  Streaming minimum-SAD selector for the full-search block-matching datapath.
//  Takes the SAD of every candidate in a GRID_W x GRID_H search window, LANES per beat,
//  in raster order. Keeps a running minimum and its candidate index.
//  After the last candidate it returns one result: the minimum SAD, its index and its
//  packed motion vector. Sits between the SAD adder array and the motion-vector writeback.
// PARAMETERS
//  SAD_W   12  width of one SAD value (unsigned)
//  GRID_W  4   search-window columns (x positions)
//  GRID_H  4   search-window rows (y positions)
//  LANES   1   candidates per input beat; GRID_W*GRID_H must be a multiple of LANES
//  MV_W    4   width of each motion-vector component in m_mv; must be >= clog2(GRID_W) and >= clog2(GRID_H)
// PORTS
//  clk      in   1              rising-edge clock
//  rst_n    in   1              async active-low reset
//  flush    in   1              sync abort of the block in progress
//  s_valid  in   1              input beat valid
//  s_ready  out  1              input beat accepted when s_valid & s_ready
//  s_sad    in   LANES*SAD_W    lane k at bits [k*SAD_W +: SAD_W]; candidate idx = beat*LANES + k
//  s_last   in   1              producer's marker on the final beat of the block
//  m_valid  out  1              result valid
//  m_ready  in   1              result consumed when m_valid & m_ready
//  m_sad    out  SAD_W          minimum SAD of the block
//  m_idx    out  clog2(NC)      raster index of the winner; NC = GRID_W*GRID_H
//  m_mv     out  2*MV_W         {y, x} of the winner, x = idx % GRID_W, y = idx / GRID_W, zero-extended
//  m_err    out  1              s_last disagreed with the beat count during this block
// BEHAVIOUR
//  Reset (async, rst_n=0): m_valid=0, m_sad=0, m_idx=0, m_mv=0, m_err=0, beat_cnt=0, state ACC.
//  States
//   ACC:  accumulating.
//   DONE: result held; m_valid=1.
//  s_ready = (state==ACC) | (m_valid & m_ready), so back-to-back blocks run with no bubble.
//  Per accepted beat
//   Comb tree picks the in-beat minimum; ties go to the lower lane.
//   Beat 0 loads run_min/run_idx unconditionally.
//   Later beats replace run_min/run_idx only if beat_min < run_min (strict).
//   Result: ties go to the lowest raster index over the whole block.
//  Final beat: beat_cnt == NC/LANES-1.
//   On the accepting edge: result registers take the final compare, m_valid <= 1,
//   beat_cnt <= 0, state <= DONE. Latency is 1 clk from the final beat to m_valid.
//  m_err is set if s_last=1 on a non-final beat, or s_last=0 on the final beat.
//   Termination is always by count, never by s_last. m_err is returned with the result.
//  DONE hold: m_* stay stable while m_valid & !m_ready.
//  DONE exit: on m_valid & m_ready, m_valid <= 0, unless a final beat is accepted on the same edge.
//  Same-edge handshake + new beat: that beat is beat 0 of the next block, accumulated normally.
//  flush=1 on any edge clears beat_cnt, the running min and the error, and drops an unconsumed
//   result (m_valid <= 0). flush has priority over every other event on that edge.
//  Arithmetic: unsigned compares only, no saturation. SAD value all-ones is a legal candidate.
//  NC/LANES == 1: every accepted beat is both beat 0 and the final beat.
// STRUCTURE
//  fsbm_pkg
//   localparam defaults: SAD_W, GRID_W, GRID_H.
//   typedef enum {ACC, DONE} sms_state_t.
//   function mv_pack(idx) -> {y, x}.
//  Sub-module sad_min_tree (combinational, LANES inputs)
//   outputs: min value and lane index; lower lane wins ties.
//   One instance, with registered state/run_min in the top level.
// TESTING
//  1. 4x4, LANES=1, SADs 100..85 descending over idx 0..15 -> m_sad=85, m_idx=15, m_mv=8'h33, m_err=0.
//  2. Ties: all 16 SADs=0x200 -> m_idx=0, m_mv=8'h00. Repeat with idx 5 and idx 9 both 0x010
//     -> m_idx=5, m_mv=8'h11.
//  3. LANES=4: beats {300,7,50,7},{9,9,9,9},{7,600,7,1},{2,1,800,900} -> m_sad=1, m_idx=11,
//     m_mv=8'h23. Result arrives 1 clk after beat 3.
//  4. Backpressure: hold m_ready=0 for 5 clk with the next block pending -> m_* stable, s_ready=0.
//     Raise m_ready -> new block beat 0 accepted on the same edge, no lost beat.
//  5. s_last asserted on beat 7 of 16 -> block still ends at beat 15, m_err=1.
//     The next clean block returns m_err=0.
//  6. flush at beat 9 -> no m_valid. A fresh 16-beat block is correct.
//     rst_n pulse mid-block -> all outputs 0 immediately.

Source files
------------

// File: rtl/fsbm_pkg.sv
// Shared types and helpers for the full-search block-matching datapath.
package fsbm_pkg;

    localparam int SAD_W  = 12;
    localparam int GRID_W = 4;
    localparam int GRID_H = 4;

    typedef enum logic {
        ACC,
        DONE
    } sms_state_t;

    // {y, x} packed at mvw bits per component; caller truncates to 2*mvw
    function automatic logic [31:0] mv_pack(
        input logic [31:0] idx,
        input int          gw,
        input int          mvw
    );
        logic [31:0] x;
        logic [31:0] y;
        x = idx % 32'(gw);
        y = idx / 32'(gw);
        return (y << mvw) | x;
    endfunction

endpackage

// File: rtl/sad_min_tree.sv
// Combinational in-beat minimum over LANES SAD values.
// Strict compare keeps the lower lane on ties.
module sad_min_tree
    import fsbm_pkg::*;
#(
    parameter int SAD_W = 12,
    parameter int LANES = 1,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*SAD_W-1:0] sad_i,
    output logic [SAD_W-1:0]       min_o,
    output logic [LW-1:0]          lane_o
);

    always_comb begin
        min_o  = sad_i[SAD_W-1:0];
        lane_o = '0;
        for (int k = 1; k < LANES; k++) begin
            if (sad_i[k*SAD_W +: SAD_W] < min_o) begin
                min_o  = sad_i[k*SAD_W +: SAD_W];
                lane_o = LW'(k);
            end
        end
    end

endmodule

// File: rtl/sad_min_select.sv
// Streaming minimum-SAD selector: running min over a search window,
// one result per block with index, packed motion vector and framing error.
module sad_min_select #(
    parameter int SAD_W  = fsbm_pkg::SAD_W,
    parameter int GRID_W = fsbm_pkg::GRID_W,
    parameter int GRID_H = fsbm_pkg::GRID_H,
    parameter int LANES  = 1,
    parameter int MV_W   = 4,
    localparam int NC    = GRID_W * GRID_H,
    localparam int IDX_W = (NC > 1) ? $clog2(NC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*SAD_W-1:0] s_sad,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [SAD_W-1:0]       m_sad,
    output logic [IDX_W-1:0]       m_idx,
    output logic [2*MV_W-1:0]      m_mv,
    output logic                   m_err
);

    import fsbm_pkg::*;

    localparam int NB   = NC / LANES;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;

    sms_state_t        state_q;
    logic [BC_W-1:0]   beat_cnt_q;
    logic [SAD_W-1:0]  run_min_q;
    logic [IDX_W-1:0]  run_idx_q;
    logic              err_q;
    logic              m_valid_q;
    logic [SAD_W-1:0]  m_sad_q;
    logic [IDX_W-1:0]  m_idx_q;
    logic [2*MV_W-1:0] m_mv_q;
    logic              m_err_q;

    logic [SAD_W-1:0]  beat_min;
    logic [LW-1:0]     beat_lane;
    logic              accept;
    logic              first_b;
    logic              final_b;
    logic              take;
    logic [SAD_W-1:0]  min_d;
    logic [IDX_W-1:0]  idx_d;
    logic              err_d;
    logic [2*MV_W-1:0] mv_d;

    sad_min_tree #(
        .SAD_W (SAD_W),
        .LANES (LANES)
    ) u_tree (
        .sad_i  (s_sad),
        .min_o  (beat_min),
        .lane_o (beat_lane)
    );

    assign s_ready = (state_q == ACC) | (m_valid_q & m_ready);
    assign accept  = s_valid & s_ready;
    assign first_b = (beat_cnt_q == '0);
    assign final_b = (beat_cnt_q == BC_W'(NB - 1));

    // Beat 0 loads unconditionally; strict compare keeps earliest index
    always_comb begin
        take  = first_b | (beat_min < run_min_q);
        min_d = take ? beat_min : run_min_q;
        idx_d = take ? (IDX_W'(beat_cnt_q) * IDX_W'(LANES)
                        + IDX_W'(beat_lane))
                     : run_idx_q;
        err_d = (first_b ? 1'b0 : err_q) | (s_last ^ final_b);
        mv_d  = (2*MV_W)'(mv_pack(32'(idx_d), GRID_W, MV_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            beat_cnt_q <= '0;
            run_min_q  <= '0;
            run_idx_q  <= '0;
            err_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_sad_q    <= '0;
            m_idx_q    <= '0;
            m_mv_q     <= '0;
            m_err_q    <= 1'b0;
        end else if (flush) begin
            state_q    <= ACC;
            beat_cnt_q <= '0;
            run_min_q  <= '0;
            run_idx_q  <= '0;
            err_q      <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            if (m_valid_q & m_ready) begin
                m_valid_q <= 1'b0;
                state_q   <= ACC;
            end
            if (accept) begin
                if (final_b) begin
                    m_sad_q    <= min_d;
                    m_idx_q    <= idx_d;
                    m_mv_q     <= mv_d;
                    m_err_q    <= err_d;
                    m_valid_q  <= 1'b1;
                    state_q    <= DONE;
                    beat_cnt_q <= '0;
                end else begin
                    run_min_q  <= min_d;
                    run_idx_q  <= idx_d;
                    err_q      <= err_d;
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_sad   = m_sad_q;
    assign m_idx   = m_idx_q;
    assign m_mv    = m_mv_q;
    assign m_err   = m_err_q;

endmodule
